// File: rtl/line_buffer_writer.sv
// Scanline buffer write side: doubles source pixels into a ping-pong bank,
// serves registered reads to the VGA stage and emits the frame sync pulse.
//
// Ports:
//   clk, reset_n           clock, async active-low reset
//   in_valid/in_ready      pixel handshake
//   in_pixel               BGR555 source pixel
//   in_sol, in_sof         start-of-line / start-of-frame qualifiers
//   rd_addr, rd_data       {bank, x} read address, data one cycle later
//   vga_sync               one-cycle VGA timing restart
//   line_done              one-cycle pulse after a line's last write
//   overflow               sticky protocol error flag
module line_buffer_writer #(
  parameter int SRC_WIDTH = 256,
  parameter int DATA_W    = 15
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_pixel,
  input  logic              in_sol,
  input  logic              in_sof,
  input  logic [9:0]        rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              vga_sync,
  output logic              line_done,
  output logic              overflow
);

  localparam int XW = (SRC_WIDTH > 1) ? $clog2(SRC_WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DUP,
    S_ACTIVE,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic                wbank_q, wbank_d;
  logic [XW-1:0]       x_q, x_d;
  logic [DATA_W-1:0]   pix_q, pix_d;
  logic                ovf_q, ovf_d;
  logic                done_q, done_d;
  logic                sync_q, sync_d;
  logic [DATA_W-1:0]   rd_q;

  logic                accept;
  logic                we;
  logic [9:0]          waddr;
  logic [DATA_W-1:0]   wdata;
  logic [8:0]          x2_even;
  logic [8:0]          x2_odd;

  logic [DATA_W-1:0]   mem [1024];

  assign in_ready  = (state_q != S_DUP);
  assign accept    = in_valid && in_ready;
  assign x2_even   = 9'({x_q, 1'b0});
  assign x2_odd    = 9'({x_q, 1'b1});

  assign rd_data   = rd_q;
  assign vga_sync  = sync_q;
  assign line_done = done_q;
  assign overflow  = ovf_q;

  always_comb begin
    state_d = state_q;
    wbank_d = wbank_q;
    x_d     = x_q;
    pix_d   = pix_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    sync_d  = 1'b0;
    we      = 1'b0;
    waddr   = '0;
    wdata   = pix_q;

    unique case (state_q)
      S_DUP: begin
        we    = 1'b1;
        waddr = {wbank_q, x2_odd};
        if (x_q == XW'(SRC_WIDTH - 1)) begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          x_d     = x_q + 1'b1;
          state_d = S_ACTIVE;
        end
      end
      S_IDLE, S_ACTIVE, S_DONE: begin
        if (accept) begin
          if (in_sol) begin
            // restarting before the line finished is an error,
            // but the new line still takes over
            if (state_q == S_ACTIVE) ovf_d = 1'b1;
            wbank_d = ~wbank_q;
            we      = 1'b1;
            waddr   = {~wbank_q, 9'd0};
            wdata   = in_pixel;
            pix_d   = in_pixel;
            x_d     = '0;
            sync_d  = in_sof;
            state_d = S_DUP;
          end else if (state_q == S_ACTIVE) begin
            we      = 1'b1;
            waddr   = {wbank_q, x2_even};
            wdata   = in_pixel;
            pix_d   = in_pixel;
            state_d = S_DUP;
          end else if (state_q == S_DONE) begin
            ovf_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      wbank_q <= 1'b0;
      x_q     <= '0;
      pix_q   <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
      sync_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wbank_q <= wbank_d;
      x_q     <= x_d;
      pix_q   <= pix_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
      sync_q  <= sync_d;
    end
  end

  // RAM has no reset; contents survive reset by design
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // same-cycle read of a written address returns the old word
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rd_q <= '0;
    else          rd_q <= mem[rd_addr];
  end

endmodule

// File: tb/tb_line_buffer_writer.sv
// Directed bench for line_buffer_writer: line fill, banking, sync,
// overflow, read latency/collision and async reset mid-duplicate.
module tb_line_buffer_writer;

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [14:0] in_pixel;
  logic        in_sol;
  logic        in_sof;
  logic [9:0]  rd_addr;
  logic [14:0] rd_data;
  logic        vga_sync;
  logic        line_done;
  logic        overflow;

  int n_vec;
  int n_err;
  int ld_cnt;

  line_buffer_writer #(.SRC_WIDTH(256), .DATA_W(15)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pixel  (in_pixel),
    .in_sol    (in_sol),
    .in_sof    (in_sof),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .vga_sync  (vga_sync),
    .line_done (line_done),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (line_done === 1'b1) ld_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [14:0] pix,
                      input logic sol,
                      input logic sof,
                      input logic exp_sync);
    chk("rdy_pre", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_pixel = pix;
    in_sol   = sol;
    in_sof   = sof;
    tick();
    in_valid = 1'b0;
    in_sol   = 1'b0;
    in_sof   = 1'b0;
    chk("rdy_dup", 32'(in_ready), 32'd0);
    chk("sync", 32'(vga_sync), 32'(exp_sync));
    tick();
    chk("sync_off", 32'(vga_sync), 32'd0);
  endtask

  task automatic rd_chk(input string tag,
                        input logic [9:0] a,
                        input logic [14:0] exp);
    rd_addr = a;
    tick();
    chk(tag, 32'(rd_data), 32'(exp));
  endtask

  // mode 0: doubled index pattern, otherwise constant val
  task automatic chk_bank(input string tag,
                          input logic bank,
                          input int mode,
                          input logic [14:0] val);
    for (int k = 0; k < 512; k++) begin
      logic [14:0] e;
      e = (mode == 0) ? 15'(k >> 1) : val;
      rd_chk(tag, {bank, 9'(k)}, e);
    end
  endtask

  initial begin
    n_vec    = 0;
    n_err    = 0;
    ld_cnt   = 0;
    reset_n  = 1'b1;
    in_valid = 1'b0;
    in_pixel = '0;
    in_sol   = 1'b0;
    in_sof   = 1'b0;
    rd_addr  = '0;
    #1 reset_n = 1'b0;
    #1;
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_rdata", 32'(rd_data), 32'd0);
    chk("rst_sync", 32'(vga_sync), 32'd0);
    chk("rst_ldone", 32'(line_done), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    tick();
    tick();
    reset_n = 1'b1;
    tick();

    // line A: index pixels, with frame start -> bank 1
    for (int i = 0; i < 256; i++)
      send(15'(i), i == 0, i == 0, i == 0);
    chk("ldone_pulse", 32'(line_done), 32'd1);
    tick();
    chk("ldone_off", 32'(line_done), 32'd0);
    chk("ldone_cnt", 32'(ld_cnt), 32'd1);
    chk("ovf_lineA", 32'(overflow), 32'd0);
    chk_bank("bank1_A", 1'b1, 0, 15'd0);

    // line B -> bank 0, bank 1 untouched
    for (int i = 0; i < 256; i++)
      send(15'h1111, i == 0, 1'b0, 1'b0);
    chk_bank("bank0_B", 1'b0, 1, 15'h1111);
    chk_bank("bank1_keepA", 1'b1, 0, 15'd0);

    // line C -> bank 1, bank 0 untouched
    for (int i = 0; i < 256; i++)
      send(15'h2222, i == 0, 1'b0, 1'b0);
    chk_bank("bank1_C", 1'b1, 1, 15'h2222);
    chk_bank("bank0_keepB", 1'b0, 1, 15'h1111);
    chk("ovf_lineC", 32'(overflow), 32'd0);

    // extra pixel after a full line is dropped and flagged
    in_valid = 1'b1;
    in_pixel = 15'h0444;
    in_sol   = 1'b0;
    tick();
    in_valid = 1'b0;
    chk("xtra_ready", 32'(in_ready), 32'd1);
    chk("xtra_ovf", 32'(overflow), 32'd1);
    rd_chk("xtra_nowrite", 10'd512, 15'h2222);

    // line D: one pixel into bank 0, then E restarts mid-line
    send(15'h0666, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 256; i++)
      send((i == 0) ? 15'h7FFF : 15'(16'h100 + i),
           i == 0, 1'b0, 1'b0);
    chk("ovf_sticky_E", 32'(overflow), 32'd1);
    rd_chk("rd_lat_512", 10'd512, 15'h7FFF);
    rd_chk("rd_1023", 10'd1023, 15'h01FF);
    rd_chk("rd_D_0", 10'd0, 15'h0666);
    rd_addr = 10'd512;

    // line F into bank 0, then G into bank 1 while reading 512
    send(15'h0333, 1'b1, 1'b0, 1'b0);
    in_valid = 1'b1;
    in_pixel = 15'h0001;
    in_sol   = 1'b1;
    tick();
    in_valid = 1'b0;
    in_sol   = 1'b0;
    chk("collide_old", 32'(rd_data), 32'h7FFF);
    tick();
    chk("collide_new", 32'(rd_data), 32'h0001);
    chk("ovf_sticky_G", 32'(overflow), 32'd1);

    // second pixel of G, then reset during its duplicate cycle
    in_valid = 1'b1;
    in_pixel = 15'h0555;
    tick();
    in_valid = 1'b0;
    chk("pre_rst_dup", 32'(in_ready), 32'd0);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_ready", 32'(in_ready), 32'd1);
    chk("arst_rdata", 32'(rd_data), 32'd0);
    chk("arst_ovf", 32'(overflow), 32'd0);
    chk("arst_sync", 32'(vga_sync), 32'd0);
    chk("arst_ldone", 32'(line_done), 32'd0);
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    rd_chk("g_even_kept", 10'd514, 15'h0555);
    rd_chk("g_dup_dropped", 10'd515, 15'h0101);

    // first line after reset goes to bank 1
    send(15'h0AAA, 1'b1, 1'b0, 1'b0);
    rd_chk("post_rst_b1", 10'd512, 15'h0AAA);
    rd_chk("post_rst_b1d", 10'd513, 15'h0AAA);
    rd_chk("post_rst_b0", 10'd0, 15'h0333);
    chk("post_rst_ovf", 32'(overflow), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
